// File: rtl/aes_ctr_sequencer_if.sv
// rtl/aes_ctr_sequencer_if.sv - data block input and result output streams of the CTR sequencer
interface aes_ctr_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_ctr_sequencer.sv
// rtl/aes_ctr_sequencer.sv - drives the shared AES core through CTR-mode blocks, one block in flight
module aes_ctr_sequencer #(
  parameter int CTR_INC_BITS   = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int NUM_KEYS       = 3
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_load,
  input  logic [127:0]         cfg_ctr,
  input  logic [1:0]           cfg_key_sel,
  input  logic                 err_clear,
  aes_ctr_sequencer_if.slave   strm,
  output logic                 aes_start,
  output logic [127:0]         aes_st,
  output logic [1:0]           aes_key_sel,
  input  logic                 aes_done,
  input  logic [127:0]         aes_ct,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [31:0]          blk_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, OUTPUT, ERROR} state_t;

  localparam int                WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT  = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [127:0]      INC_MASK   = (128'd1 << CTR_INC_BITS) - 128'd1;
  localparam logic [31:0]       NUM_KEYS_U = NUM_KEYS;

  state_t            state;
  state_t            state_nxt;
  logic [127:0]      ctr;
  logic [1:0]        key_sel;
  logic [127:0]      data;
  logic              data_last;
  logic [127:0]      out_data;
  logic              out_last;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       blk_cnt;
  logic              armed;
  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              done_seen;
  logic              timed_out;

  // armed keeps in_ready low until the first clock after reset release
  assign accept    = (state == IDLE) && armed && !cfg_load && strm.in_valid;
  assign done_seen = (state == WAIT_DONE) && (wait_cnt != '0) && aes_done;
  assign timed_out = (state == WAIT_DONE) && !done_seen && (wait_cnt == LAST_WAIT);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (done_seen)      state_nxt = OUTPUT;
        else if (timed_out) state_nxt = ERROR;
      end
      OUTPUT:    if (strm.out_ready) state_nxt = IDLE;
      ERROR:     if (err_clear) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    aes_start   = 1'b0;
    busy        = 1'b1;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        in_ready = armed && !cfg_load;
        busy     = 1'b0;
      end
      ISSUE:   aes_start   = 1'b1;
      OUTPUT:  out_valid   = 1'b1;
      ERROR:   err_timeout = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      armed     <= 1'b0;
      ctr       <= '0;
      key_sel   <= '0;
      data      <= '0;
      data_last <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      wait_cnt  <= '0;
      blk_cnt   <= '0;
    end else begin
      armed <= 1'b1;
      if (state == IDLE && cfg_load) begin
        ctr     <= cfg_ctr;
        key_sel <= (32'(cfg_key_sel) < NUM_KEYS_U) ? cfg_key_sel : 2'd0;
        blk_cnt <= '0;
      end
      if (accept) begin
        data      <= strm.in_data;
        data_last <= strm.in_last;
      end
      wait_cnt <= (state == WAIT_DONE) ? wait_cnt + 1'b1 : '0;
      // only the low CTR_INC_BITS of the counter advance; carry never leaves the field
      if (done_seen) begin
        out_data <= data ^ aes_ct;
        out_last <= data_last;
        ctr      <= (ctr & ~INC_MASK) | ((ctr + 128'd1) & INC_MASK);
        blk_cnt  <= blk_cnt + 32'd1;
      end
    end
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid;
  assign strm.out_data  = out_data;
  assign strm.out_last  = out_last;
  assign aes_st         = ctr;
  assign aes_key_sel    = key_sel;
  assign blk_count      = blk_cnt;

endmodule
